// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control unit: sequences fetch/execute/writeback/interrupt
// entry and counts retired instructions.
module otter_cu_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        intr,
  input  logic        mem_ready,
  output logic        pc_rst,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_rden1,
  output logic        mem_rden2,
  output logic        mem_we2,
  output logic        csr_we,
  output logic        int_taken,
  output logic        mret_exec,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam int unsigned CNT_W = 32;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_INTR  = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_next_state;
  end

  // Next-state and strobe decode
  always_comb begin
    w_next_state = r_state;
    pc_rst       = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    mem_rden1    = 1'b0;
    mem_rden2    = 1'b0;
    mem_we2      = 1'b0;
    csr_we       = 1'b0;
    int_taken    = 1'b0;
    mret_exec    = 1'b0;
    illegal      = 1'b0;
    case (r_state)
      ST_INIT: begin
        pc_rst       = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rden1    = 1'b1;
        w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        w_next_state = intr ? ST_INTR : ST_FETCH;
        case (opcode)
          OP_LOAD: begin
            mem_rden2    = 1'b1;
            w_next_state = ST_WB;
          end
          OP_STORE: begin
            mem_we2  = 1'b1;
            pc_write = 1'b1;
          end
          OP_BRANCH: pc_write = 1'b1;
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP: begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
          end
          OP_SYSTEM: begin
            pc_write = 1'b1;
            if (func3 == 3'b000) begin
              mret_exec = 1'b1;
            end else begin
              reg_write = 1'b1;
              csr_we    = 1'b1;
            end
          end
          default: begin
            pc_write = 1'b1;
            illegal  = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        // Stall indefinitely until load data is valid
        if (mem_ready) begin
          pc_write     = 1'b1;
          reg_write    = 1'b1;
          w_next_state = intr ? ST_INTR : ST_FETCH;
        end
      end
      ST_INTR: begin
        int_taken    = 1'b1;
        pc_write     = 1'b1;
        w_next_state = ST_FETCH;
      end
      default: w_next_state = ST_INIT;
    endcase
  end

  // Retirement: PC advance from EXEC or WB only, never interrupt entry
  assign w_retire = pc_write && ((r_state == ST_EXEC) || (r_state == ST_WB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + CNT_W'(1);
  end

  assign instret = r_instret;

endmodule
